// File: rtl/step_pulse_gen.sv
// step_pulse_gen: converts a signed velocity word into STEP/DIR pulses for a
// stepper driver. A phase accumulator produces step events, a one-deep pending
// slot buffers one event, and a small FSM enforces direction setup, step high
// time and minimum step low time while tracking the absolute position.
module step_pulse_gen #(
  parameter int unsigned ACC_W         = 24,
  parameter int unsigned STEP_HIGH_CYC = 4,
  parameter int unsigned STEP_LOW_CYC  = 4,
  parameter int unsigned DIR_SETUP_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_velocity,
  input  logic        i_clr_pos,
  output logic        o_step,
  output logic        o_dir,
  output logic [31:0] o_position,
  output logic        o_busy,
  output logic        o_overrun
);

  // Sum is wide enough for both the accumulator and a 15-bit magnitude, so a
  // magnitude at or above 2^ACC_W still registers as a wrap on every edge.
  localparam int unsigned SUM_W   = ((ACC_W > 15) ? ACC_W : 15) + 1;
  localparam int unsigned CNT_MAX =
    (STEP_HIGH_CYC > STEP_LOW_CYC)
      ? ((STEP_HIGH_CYC > DIR_SETUP_CYC) ? STEP_HIGH_CYC : DIR_SETUP_CYC)
      : ((STEP_LOW_CYC  > DIR_SETUP_CYC) ? STEP_LOW_CYC  : DIR_SETUP_CYC);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ACC_W-1:0]   acc;
  logic [SUM_W-1:0]   sum;
  logic [14:0]        mag;
  logic               carry;
  logic               step_ev;
  logic               pending, pending_nxt;
  logic               pend_dir, pend_dir_nxt;
  logic               consume;
  logic               dir_nxt;
  logic               step_nxt;
  logic               busy_nxt;
  logic               overrun_nxt;
  logic [31:0]        pos_nxt;

  // Velocity magnitude; -32768 has no positive counterpart and saturates.
  always_comb begin
    mag = i_velocity[14:0];
    if (i_velocity[15]) begin
      if (i_velocity[14:0] == '0) mag = '1;
      else                        mag = 15'(~i_velocity[14:0]) + 15'd1;
    end
  end

  // Accumulator sum and wrap detection.
  always_comb begin
    sum     = SUM_W'(acc) + SUM_W'(mag);
    carry   = |sum[SUM_W-1:ACC_W];
    step_ev = i_enable & carry;
  end

  // Phase accumulator register; cleared while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      acc <= '0;
    else if (i_enable) acc <= sum[ACC_W-1:0];
    else               acc <= '0;
  end

  // Next-state, pending slot, position and output decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dir_nxt      = o_dir;
    pending_nxt  = pending;
    pend_dir_nxt = pend_dir;
    overrun_nxt  = o_overrun;
    pos_nxt      = o_position;
    consume      = 1'b0;

    case (state)
      S_IDLE: begin
        if (pending) begin
          consume = 1'b1;
          if (pend_dir == o_dir) begin
            state_nxt = S_HIGH;
            cnt_nxt   = CNT_W'(STEP_HIGH_CYC - 1);
          end else begin
            dir_nxt   = pend_dir;
            state_nxt = S_SETUP;
            cnt_nxt   = CNT_W'(DIR_SETUP_CYC - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_W'(STEP_HIGH_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt == '0) begin
          state_nxt = S_LOW;
          cnt_nxt   = CNT_W'(STEP_LOW_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_LOW: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Consumption frees the slot before a same-edge event refills it, so a
    // simultaneous consume+event is a hand-over, not an overrun.
    if (consume) pending_nxt = 1'b0;
    if (step_ev) begin
      if (pending && !consume) begin
        overrun_nxt = 1'b1;
      end else begin
        pending_nxt  = 1'b1;
        pend_dir_nxt = i_velocity[15];
      end
    end

    if (i_clr_pos)
      pos_nxt = '0;
    else if ((state_nxt == S_HIGH) && (state != S_HIGH))
      pos_nxt = dir_nxt ? (o_position - 32'd1) : (o_position + 32'd1);

    step_nxt = (state_nxt == S_HIGH);
    busy_nxt = (state_nxt != S_IDLE) | pending_nxt;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      pend_dir   <= 1'b0;
      o_step     <= 1'b0;
      o_dir      <= 1'b0;
      o_position <= '0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      pend_dir   <= pend_dir_nxt;
      o_step     <= step_nxt;
      o_dir      <= dir_nxt;
      o_position <= pos_nxt;
      o_busy     <= busy_nxt;
      o_overrun  <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: directed scenarios plus randomized velocity
// segments, checked every cycle against a timeline-based reference model.
module tb_step_pulse_gen;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned SH    = 4;
  localparam int unsigned SL    = 4;
  localparam int unsigned DS    = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic [15:0] i_velocity;
  logic        i_clr_pos;
  logic        o_step;
  logic        o_dir;
  logic [31:0] o_position;
  logic        o_busy;
  logic        o_overrun;

  step_pulse_gen #(
    .ACC_W(ACC_W),
    .STEP_HIGH_CYC(SH),
    .STEP_LOW_CYC(SL),
    .DIR_SETUP_CYC(DS)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_enable(i_enable),
    .i_velocity(i_velocity),
    .i_clr_pos(i_clr_pos),
    .o_step(o_step),
    .o_dir(o_dir),
    .o_position(o_position),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;
  int busy_lows = 0;

  // Reference model: accumulator arithmetic plus a timeline of pulse
  // start / free times instead of explicit FSM states.
  int          m_acc;
  bit          m_pv, m_pd, m_dir, m_ovr, m_has;
  longint      m_free, m_rise;
  logic [31:0] m_pos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_pv = 0; m_pd = 0; m_dir = 0; m_ovr = 0; m_has = 0;
    m_free = 0; m_rise = 0; m_pos = '0;
  endtask

  task automatic model_edge(input longint n);
    int v, mag, sum;
    bit ev, consume;
    v = $signed(i_velocity);
    mag = (v < 0) ? -v : v;
    if (mag > 32767) mag = 32767;
    consume = m_pv && (n >= m_free);
    ev = 0;
    if (i_enable) begin
      sum   = m_acc + mag;
      ev    = (sum >= (1 << ACC_W));
      m_acc = sum % (1 << ACC_W);
    end else begin
      m_acc = 0;
    end
    if (consume) begin
      if (m_pd != m_dir) begin
        m_dir  = m_pd;
        m_rise = n + DS;
      end else begin
        m_rise = n;
      end
      m_has  = 1;
      m_free = m_rise + SH + SL + 1;
      m_pv   = 0;
    end
    if (ev) begin
      if (m_pv) m_ovr = 1;
      else begin
        m_pv = 1;
        m_pd = (v < 0);
      end
    end
    if (i_clr_pos) m_pos = '0;
    else if (m_has && n == m_rise) m_pos = m_dir ? (m_pos - 32'd1) : (m_pos + 32'd1);
  endtask

  task automatic tick();
    bit e_step, e_busy;
    @(posedge i_clk);
    cyc++;
    if (!i_rst_n) model_reset();
    else model_edge(cyc);
    #1;
    e_step = m_has && (cyc >= m_rise) && (cyc < m_rise + SH);
    e_busy = m_pv || (m_has && (cyc + 1 < m_free));
    if (!o_busy) busy_lows++;
    chk("step", 32'(o_step), 32'(e_step));
    chk("dir", 32'(o_dir), 32'(m_dir));
    chk("position", o_position, m_pos);
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic wait_rise(input string tag, input int budget, output longint at);
    bit prev, found;
    prev = o_step; found = 0; at = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (!prev && o_step) begin found = 1; at = cyc; end
      prev = o_step;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_dir(input string tag, input int budget, output longint at);
    bit prev, found;
    prev = o_dir; found = 0; at = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (prev != o_dir) begin found = 1; at = cyc; end
      prev = o_dir;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0, r, r_prev, d, f;
    int highs;
    logic [31:0] p1;
    int vel_tab[10];

    model_reset();
    i_rst_n = 1'b0; i_enable = 1'b1; i_velocity = 16'd0; i_clr_pos = 1'b0;
    tick(); tick();
    chk("rst_step", 32'(o_step), 32'd0);
    chk("rst_pos", o_position, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst_n = 1'b1;

    // 1: zero velocity never steps
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (o_step) highs++;
    end
    chk("t1_no_step", 32'(highs), 32'd0);
    chk("t1_pos", o_position, 32'd0);
    chk("t1_busy", 32'(o_busy), 32'd0);

    // 2: velocity 16 -> one pulse every 16 clocks, first rise 17 edges in
    i_velocity = 16'd16;
    c0 = cyc;
    r_prev = 0;
    for (int i = 0; i < 10; i++) begin
      wait_rise("t2_rise_timeout", 60, r);
      if (i == 0) chk("t2_first_rise", 32'(r - c0), 32'd17);
      else        chk("t2_period", 32'(r - r_prev), 32'd16);
      if (i == 0) begin
        highs = 0;
        while (o_step && highs < 10) begin tick(); highs++; end
        chk("t2_high_time", 32'(highs), 32'(SH));
      end
      r_prev = r;
    end
    chk("t2_pos", o_position, 32'd10);
    chk("t2_dir", 32'(o_dir), 32'd0);

    // 3: reverse to -16 -> dir flips, step follows DS edges later
    i_velocity = -16'sd16;
    wait_dir("t3_dir_timeout", 60, d);
    chk("t3_dir_val", 32'(o_dir), 32'd1);
    wait_rise("t3_rise_timeout", 20, r);
    chk("t3_setup", 32'(r - d), 32'(DS));
    chk("t3_pos_first", o_position, 32'd9);
    for (int i = 0; i < 4; i++) wait_rise("t3_rise_timeout", 60, r);
    chk("t3_pos", o_position, 32'd5);
    chk("t3_overrun", 32'(o_overrun), 32'd0);

    // 4: velocity 64 -> back-to-back 9-clock pulses, overrun, busy held
    i_velocity = 16'd64;
    wait_rise("t4_rise_timeout", 60, r_prev);
    busy_lows = 0;
    for (int i = 0; i < 6; i++) begin
      wait_rise("t4_rise_timeout", 30, r);
      chk("t4_period", 32'(r - r_prev), 32'd9);
      r_prev = r;
    end
    chk("t4_busy_held", 32'(busy_lows), 32'd0);
    chk("t4_overrun", 32'(o_overrun), 32'd1);

    // 5: -32768 saturates to max rate in the negative direction
    i_velocity = 16'h8000;
    wait_rise("t5_rise_timeout", 60, r_prev);
    p1 = o_position;
    for (int i = 0; i < 5; i++) begin
      wait_rise("t5_rise_timeout", 30, r);
      chk("t5_period", 32'(r - r_prev), 32'd9);
      r_prev = r;
    end
    chk("t5_dir", 32'(o_dir), 32'd1);
    chk("t5_pos", o_position, p1 - 32'd5);

    // Randomized velocity / enable / clear segments
    vel_tab = '{0, 16, -16, 64, -64, 100, -7, 32767, -32768, 300};
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(3, 0) == 0) i_velocity = 16'($urandom_range(65535, 0));
      else i_velocity = 16'(vel_tab[$urandom_range(9, 0)]);
      i_enable = ($urandom_range(4, 0) != 0);
      for (int i = 0; i < 40; i++) begin
        i_clr_pos = ($urandom_range(19, 0) == 0);
        tick();
      end
      i_clr_pos = 1'b0;
    end
    i_enable = 1'b1;

    // 6a: async reset in the middle of a high phase
    i_velocity = 16'd16;
    wait_rise("t6_rise_timeout", 300, r);
    tick();
    #3;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_step", 32'(o_step), 32'd0);
    chk("t6_rst_dir", 32'(o_dir), 32'd0);
    chk("t6_rst_pos", o_position, 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_overrun", 32'(o_overrun), 32'd0);
    tick();
    i_rst_n = 1'b1;

    // 6b: clear on the step-entry edge of the second pulse wins
    for (int i = 0; i < 32; i++) tick();
    chk("t6_pos_before", o_position, 32'd1);
    i_clr_pos = 1'b1;
    tick();
    i_clr_pos = 1'b0;
    chk("t6_clr_step", 32'(o_step), 32'd1);
    chk("t6_clr_pos", o_position, 32'd0);
    wait_rise("t6_rise_timeout", 30, f);
    chk("t6_pos_after", o_position, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Downstream stage of the velocity S-curve workbench. It consumes the 16-bit signed velocity word the workbench produces and converts it into STEP/DIR pulses for a stepper driver using a phase accumulator. It enforces the driver's pulse width, minimum low time and direction setup time, and tracks the absolute position.

Parameters:
ACC_W, 24, phase accumulator width; step rate = |velocity| * f_clk / 2^ACC_W
STEP_HIGH_CYC, 4, o_step high time in clocks (>=1)
STEP_LOW_CYC, 4, minimum o_step low time after each pulse in clocks (>=1)
DIR_SETUP_CYC, 2, clocks between an o_dir change and the next o_step rise (>=1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  1 = accumulate velocity; 0 = accumulator cleared, no new step events
i_velocity  in  16  signed two's-complement velocity, connected to the workbench o_value
i_clr_pos  in  1  synchronous clear of o_position
o_step  out  1  step pulse to driver
o_dir  out  1  direction: 0 = positive, 1 = negative
o_position  out  32  signed step count, wraps two's-complement
o_busy  out  1  high when the FSM is not IDLE or a step is pending
o_overrun  out  1  sticky flag: a step event was dropped

Behaviour:
- Clocking and reset: one clock domain; i_rst_n is asynchronous and active-low.
- Reset (async, immediate, including mid-pulse): acc=0, pending=0, FSM=IDLE, o_step=0, o_dir=0, o_position=0, o_busy=0, o_overrun=0.
- Magnitude: mag = |i_velocity|. The value -32768 saturates to 32767. The sign is taken from i_velocity bit 15.
- Accumulator:
  - When i_enable=1, each edge computes {carry, acc} <= acc + mag at ACC_W+1 bits.
  - carry=1 is a step event; its direction is the velocity sign in that cycle.
  - When i_enable=0, acc <= 0 and no events occur. An in-flight pulse and any pending step still complete.
- Pending register (1 deep, holds the requested direction):
  - A step event sets pending on the same edge as the accumulator wrap.
  - An event arriving while pending is full and not being consumed that edge is dropped and sets o_overrun (sticky until reset).
  - If pending is consumed and a new event arrives on the same edge, pending stays set with the new direction. This is not an overrun.
- FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE: if pending, consume it.
    - If the requested direction equals o_dir: go to HIGH.
    - Otherwise: o_dir <= requested direction and go to SETUP.
  - SETUP: count DIR_SETUP_CYC clocks, then go to HIGH.
  - HIGH: o_step=1 for exactly STEP_HIGH_CYC clocks, then go to LOW. On entry to HIGH, o_position is incremented (o_dir=0) or decremented (o_dir=1).
  - LOW: o_step=0 for STEP_LOW_CYC clocks, then go to IDLE.
- Latency:
  - Same direction: o_step rises on the edge after the edge at which acc wrapped.
  - Direction change: o_dir changes on that edge, and o_step rises DIR_SETUP_CYC edges later.
- Maximum step rate: one pulse per STEP_HIGH_CYC+STEP_LOW_CYC+1 clocks (9 with defaults). At higher requested rates pulses run back-to-back at this period and excess events set o_overrun.
- o_step and o_dir are registered outputs with no glitches. o_dir never changes while in HIGH or LOW.
- i_clr_pos: o_position <= 0 on the next edge. If a step is counted on the same edge, the clear wins and that step is not counted.
- o_busy = (FSM != IDLE) | pending, registered.

Test Plan:
1. Bench overrides ACC_W=8. Release reset with i_enable=1 and i_velocity=0 for 1000 clocks -> o_step never rises; o_position=0; o_busy=0.
2. i_velocity=16 -> first wrap on the 16th enabled edge and o_step rises 1 edge later. o_step is high for 4 clocks, the pulse period is exactly 16 clocks, and o_position=+10 after 10 pulses with o_dir=0.
3. After case 2, set i_velocity=-16 -> o_dir goes to 1 one edge after the next wrap and o_step rises 2 edges after that. o_position decrements by 1 per pulse and o_overrun stays 0.
4. i_velocity=64 (a wrap every 4 clocks) -> pulses run back-to-back with a 9-clock period, o_overrun=1, and o_busy stays 1 continuously.
5. i_velocity=-32768 -> treated as mag 32767 with dir=1. The pulse period is 9 clocks and o_position decreases by 1 per pulse.
6. Assert i_rst_n=0 mid-HIGH -> o_step=0 immediately and all outputs return to reset values. Separately, pulse i_clr_pos on a step-entry edge -> o_position=0, with that step not counted.
